// File: rtl/bit8_1to2_stream_demux.sv
// bit8_1to2_stream_demux: steers one byte stream to two independently buffered, handshaked output ports
module bit8_1to2_stream_demux #(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in_data,
    input  logic          in_sel,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [7:0]    out0_data,
    output logic          out0_valid,
    input  logic          out0_ready,
    output logic [7:0]    out1_data,
    output logic          out1_valid,
    input  logic          out1_ready,
    output logic [AW:0]   count0,
    output logic [AW:0]   count1,
    output logic [7:0]    sent0,
    output logic [7:0]    sent1
);
    localparam logic [AW:0] full = (AW + 1)'(DEPTH);
    logic [1:0] rdy;
    assign rdy = {out1_ready, out0_ready};
    // registered counts only, so a same-cycle pop never frees room for a push
    assign in_ready = (in_sel ? g_fifo[1].cnt : g_fifo[0].cnt) != full;
    for (genvar n = 0; n < 2; n++) begin : g_fifo
        logic [7:0]    mem [DEPTH];
        logic [AW-1:0] rp, wp;
        logic [AW:0]   cnt;
        logic [7:0]    sent;
        logic          push, pop, valid;
        logic [7:0]    head;
        assign valid = cnt != '0;
        assign push  = in_valid && in_ready && in_sel == 1'(n);
        assign pop   = valid && rdy[n];
        assign head  = mem[rp];
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
                rp   <= '0;
                wp   <= '0;
                cnt  <= '0;
                sent <= '0;
            end else begin
                if (push) begin
                    mem[wp] <= in_data;
                    wp      <= wp + 1'b1;
                end
                if (pop) begin
                    rp   <= rp + 1'b1;
                    sent <= sent + 8'd1;
                end
                if (push != pop) cnt <= push ? cnt + 1'b1 : cnt - 1'b1;
            end
        end
    end
    assign out0_data  = g_fifo[0].head;
    assign out1_data  = g_fifo[1].head;
    assign out0_valid = g_fifo[0].valid;
    assign out1_valid = g_fifo[1].valid;
    assign count0     = g_fifo[0].cnt;
    assign count1     = g_fifo[1].cnt;
    assign sent0      = g_fifo[0].sent;
    assign sent1      = g_fifo[1].sent;
endmodule

// File: tb/tb_bit8_1to2_stream_demux.sv
// tb_bit8_1to2_stream_demux: directed plus random stimulus, scoreboarded against per-port queues
module tb_bit8_1to2_stream_demux;
    localparam int DEPTH = 2;
    localparam int AW    = 1;
    logic        clk = 0, reset = 1, in_sel = 0, in_valid = 0, out0_ready = 0, out1_ready = 0;
    logic [7:0]  in_data = 0;
    logic        in_ready, out0_valid, out1_valid;
    logic [7:0]  out0_data, out1_data, sent0, sent1;
    logic [AW:0] count0, count1;
    bit          armed = 0, pop0 = 0, pop1 = 0;
    logic [7:0]  q0[$], q1[$];
    int          sent_m0 = 0, sent_m1 = 0, tests = 0, fails = 0;

    bit8_1to2_stream_demux #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(in_ready), .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
        .count0(count0), .count1(count1), .sent0(sent0), .sent1(sent1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] d,
                         input logic r0, input logic r1, input logic rs = 1'b0);
        in_valid = v; in_sel = s; in_data = d; out0_ready = r0; out1_ready = r1; reset = rs;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        drive(0, 0, 8'h00, 1, 1);
        while ((q0.size() != 0 || q1.size() != 0) && k < 20) begin
            tick();
            k++;
        end
        chk("drain count0", 32'(count0), 0);
        chk("drain count1", 32'(count1), 0);
    endtask

    // Reference model: each port is an ordered queue of at most DEPTH words
    initial forever begin
        @(posedge clk);
        if (reset) begin
            q0.delete(); q1.delete();
            sent_m0 = 0; sent_m1 = 0;
        end else begin
            if (in_valid && !in_sel && q0.size() < DEPTH) q0.push_back(in_data);
            if (in_valid && in_sel && q1.size() < DEPTH) q1.push_back(in_data);
            if (pop0) begin void'(q0.pop_front()); sent_m0 = (sent_m0 + 1) % 256; end
            if (pop1) begin void'(q1.pop_front()); sent_m1 = (sent_m1 + 1) % 256; end
        end
    end

    initial forever begin
        @(negedge clk);
        pop0 = 0; pop1 = 0;
        if (armed) begin
            chk("in_ready", 32'(in_ready), 32'((in_sel ? q1.size() : q0.size()) != DEPTH));
            chk("count0", 32'(count0), q0.size());
            chk("count1", 32'(count1), q1.size());
            chk("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
            chk("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
            chk("sent0", 32'(sent0), sent_m0);
            chk("sent1", 32'(sent1), sent_m1);
            if (q0.size() != 0) begin
                chk("out0_data", 32'(out0_data), 32'(q0[0]));
                pop0 = out0_ready && !reset;
            end
            if (q1.size() != 0) begin
                chk("out1_data", 32'(out1_data), 32'(q1[0]));
                pop1 = out1_ready && !reset;
            end
        end
    end

    initial begin
        if (AW != $clog2(DEPTH)) begin
            $display("FAIL param AW: got %0d, expected %0d", AW, $clog2(DEPTH));
            $fatal(1, "bad AW");
        end
        drive(0, 0, 8'h00, 0, 0, 1);
        tick(); tick();
        armed = 1;
        drive(0, 0, 8'h00, 0, 0);
        @(negedge clk);
        chk("reset in_ready", 32'(in_ready), 1);
        chk("reset out0_data", 32'(out0_data), 0);
        chk("reset out1_data", 32'(out1_data), 0);
        tick();
        // single word through port 0
        drive(1, 0, 8'hA5, 1, 0);
        tick();
        drive(0, 0, 8'h00, 1, 0);
        @(negedge clk);
        chk("t1 out0_valid", 32'(out0_valid), 1);
        chk("t1 out0_data", 32'(out0_data), 32'hA5);
        tick();
        drive(0, 0, 8'h00, 1, 0);
        @(negedge clk);
        chk("t1 out0_valid after pop", 32'(out0_valid), 0);
        chk("t1 sent0", 32'(sent0), 1);
        chk("t1 out1_valid", 32'(out1_valid), 0);
        tick();
        // fill port 1, then a blocked port-1 offer while port 0 still accepts
        drive(1, 1, 8'h11, 1, 0); tick();
        drive(1, 1, 8'h22, 1, 0); tick();
        drive(1, 1, 8'h33, 1, 0);
        @(negedge clk);
        chk("t2 in_ready full", 32'(in_ready), 0);
        chk("t2 count1", 32'(count1), 2);
        #1;
        drive(1, 0, 8'h44, 1, 0);
        @(negedge clk);
        chk("t2 in_ready other", 32'(in_ready), 1);
        tick();
        // full port 1: push refused even though it pops this cycle
        drive(1, 1, 8'h55, 1, 1);
        @(negedge clk);
        chk("t3 in_ready", 32'(in_ready), 0);
        tick();
        drive(0, 0, 8'h00, 0, 0);
        @(negedge clk);
        chk("t3 count1", 32'(count1), 1);
        chk("t3 out1_data", 32'(out1_data), 32'h22);
        tick();
        drain();
        // push and pop together on port 0 holds the count
        drive(1, 0, 8'h61, 0, 0); tick();
        drive(1, 0, 8'h62, 1, 0);
        @(negedge clk);
        chk("t4 count0 before", 32'(count0), 1);
        chk("t4 out0_data first", 32'(out0_data), 32'h61);
        tick();
        drive(0, 0, 8'h00, 0, 0);
        @(negedge clk);
        chk("t4 count0 after", 32'(count0), 1);
        chk("t4 out0_data second", 32'(out0_data), 32'h62);
        tick();
        drain();
        // 260 words through port 0 wrap both pointers and sent0
        drive(0, 0, 8'h00, 0, 0, 1); tick();
        for (int i = 0; i < 260; i++) begin
            drive(1, 0, 8'(i), 1, 0);
            tick();
        end
        drain();
        @(negedge clk);
        chk("t5 sent0 wrap", 32'(sent0), 4);
        // reset mid-stream drops buffered words and the reset-cycle push
        drive(1, 0, 8'hA1, 0, 0); tick();
        drive(1, 0, 8'hA2, 0, 0); tick();
        drive(1, 0, 8'hA3, 0, 0, 1); tick();
        drive(0, 0, 8'h00, 1, 1);
        @(negedge clk);
        chk("t6 count0", 32'(count0), 0);
        chk("t6 out0_valid", 32'(out0_valid), 0);
        chk("t6 out0_data", 32'(out0_data), 0);
        chk("t6 in_ready", 32'(in_ready), 1);
        chk("t6 sent0", 32'(sent0), 0);
        tick(); tick(); tick();
        @(negedge clk);
        chk("t6 nothing delivered", 32'(sent0), 0);
        // random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 59) == 0));
            tick();
        end
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bit8_1to2_stream_demux.md
Name: bit8_1to2_stream_demux

Overview:
8-bit, 1-to-2 stream demultiplexer with buffered, handshaked outputs. It is the inverse of the team's 8-bit 2-to-1 mux: a single producer stream is steered to one of two consumer ports by a per-word select bit. Each output port has its own small FIFO, so a stalled consumer only blocks words addressed to it. It sits between a shared byte source and two independent byte sinks.

Parameters:
DEPTH, 2, entries per output FIFO; must be a power of 2, minimum 2.
AW, 1, log2(DEPTH); must equal log2(DEPTH), checked by the bench.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
in_data  input  8  word offered by the producer.
in_sel  input  1  destination of in_data: 0 routes to port 0, 1 routes to port 1.
in_valid  input  1  producer offers in_data/in_sel this cycle.
in_ready  output  1  combinational; 1 when the FIFO selected by in_sel is not full.
out0_data  output  8  head word of FIFO 0.
out0_valid  output  1  FIFO 0 not empty.
out0_ready  input  1  consumer 0 accepts head this cycle.
out1_data  output  8  head word of FIFO 1.
out1_valid  output  1  FIFO 1 not empty.
out1_ready  input  1  consumer 1 accepts head this cycle.
count0  output  AW+1  occupancy of FIFO 0, range 0..DEPTH.
count1  output  AW+1  occupancy of FIFO 1, range 0..DEPTH.
sent0  output  8  words popped from port 0; wraps 255 -> 0.
sent1  output  8  words popped from port 1; wraps 255 -> 0.

Behaviour:
- Push: in_valid && in_ready. The word is written to FIFO[in_sel] at the edge. The other FIFO is untouched.
- Pop on port N: outN_valid && outN_ready. The head is removed at the edge.
- in_ready = (in_sel ? count1 : count0) != DEPTH. It depends only on in_sel and the registered count, with no combinational path from outN_ready.
  - Consequence: a full FIFO refuses a push even if it is popped in the same cycle.
- Latency: a word pushed into an empty FIFO appears on outN_data with outN_valid=1 in the next cycle. Order within each port is preserved (FIFO order).
- outN_valid = (countN != 0). outN_data is driven from registered storage at the read pointer. Its value is don't-care when outN_valid=0, but it must not be X after reset; storage is reset to 0.
- Pointers: AW-bit read and write pointers per FIFO, wrapping DEPTH-1 -> 0.
  - countN increments on push-only, decrements on pop-only, and holds on push+pop or on no activity.
- Simultaneous push to FIFO N and pop from FIFO N (possible only when 0 < countN < DEPTH): both occur and countN is unchanged.
- Simultaneous push to FIFO A and pop from FIFO B (A != B): independent updates.
- Producer stall: if in_ready=0 the producer holds in_data/in_sel. The block places no requirement on stability, because nothing is captured until the push.
- sentN increments by 1 on each pop from port N, modulo 256.
- Reset: clears all pointers, counts, storage and counters. After reset: in_ready=1, out0_valid=0, out1_valid=0, out0_data=0, out1_data=0, count0=count1=0, sent0=sent1=0.
  - Reset asserted mid-stream discards all buffered words; any push or pop in the reset cycle is ignored.
- No state machine beyond the two FIFO controllers. There is no arbitration, because there is only one producer.

Test Plan:
1. Reset, then push 0xA5 with sel=0, out0_ready=1 -> next cycle out0_valid=1, out0_data=0xA5; the following cycle out0_valid=0, sent0=1, out1_valid stays 0.
2. out1_ready=0; push 0x11, 0x22 with sel=1 (DEPTH=2) -> count1=2; third offer (0x33, sel=1) sees in_ready=0. Same cycle, offer sel=0 sees in_ready=1 and is accepted to port 0.
3. count1=2, push and pop port 1 in the same cycle -> push refused, pop succeeds, count1=1, out1_data=0x22.
4. count0=1, push sel=0 with out0_ready=1 -> count0 stays 1, and data order 1st, 2nd is preserved over the following cycles.
5. Stream 260 words to port 0 with out0_ready=1 -> sent0=4 (wrap); data order is intact across pointer wrap.
6. Load FIFO 0 with 2 words, assert reset for one cycle with in_valid=1 -> all outputs at reset values, count0=0, no word delivered afterwards.
